pulse_wave_gen: RTL and testbench

PULSE_WAVE_GEN -- requirements
Module: pulse_wave_gen

---
 rtl/pulse_wave_gen.sv | 124 ++++++++++++
 tb/tb_pulse_wave_gen.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_wave_gen.sv
// Gated pulse-wave oscillator: duty-compared phase accumulator, volume-scaled signed samples.
// Latency 2 clocks from sample_tick to data_out/data_valid; no backpressure, a tick every cycle is accepted.
module pulse_wave_gen #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 24,
    parameter int DUTY_W = 8,
    parameter int VOL_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sample_tick,
    input  logic                     gate,
    input  logic [ACC_W-1:0]         phase_inc,
    input  logic [DUTY_W-1:0]        duty,
    input  logic [VOL_W-1:0]         volume,
    output logic signed [DATA_W-1:0] data_out,
    output logic                     data_valid,
    output logic                     cycle_wrap
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    localparam logic signed [DATA_W-1:0] LVL_HI = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] LVL_LO = {1'b1, {(DATA_W-2){1'b0}}, 1'b1};

    logic [1:0]               state, state_nxt;
    logic [ACC_W-1:0]         acc, acc_nxt;
    logic [DUTY_W-1:0]        duty_q, duty_nxt;
    logic [ACC_W:0]           acc_sum;
    logic                     carry;
    logic [DUTY_W-1:0]        hi;
    logic signed [DATA_W-1:0] level_nxt;
    logic                     wrap_nxt;

    logic signed [DATA_W-1:0] level_q;
    logic [VOL_W-1:0]         vol_q;
    logic                     vld_q;

    logic signed [DATA_W+VOL_W-1:0] level_ext, vol_ext, prod;

    assign acc_sum = {1'b0, acc} + {1'b0, phase_inc};
    assign carry   = acc_sum[ACC_W];
    assign hi      = acc[ACC_W-1 -: DUTY_W];

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        duty_nxt  = duty_q;
        level_nxt = '0;
        wrap_nxt  = 1'b0;
        case (state)
            IDLE: begin
                // The note-on tick itself emits the phase-0 sample against the fresh duty.
                if (gate) begin
                    state_nxt = RUN;
                    acc_nxt   = phase_inc;
                    duty_nxt  = duty;
                    level_nxt = (duty != '0) ? LVL_HI : LVL_LO;
                end
            end
            RUN, RELEASE: begin
                level_nxt = (hi < duty_q) ? LVL_HI : LVL_LO;
                acc_nxt   = acc_sum[ACC_W-1:0];
                if (carry) begin
                    wrap_nxt = 1'b1;
                    duty_nxt = duty;
                end
                // A wrap ends the note when released; otherwise gate picks RUN or RELEASE.
                if (carry && (state == RELEASE || !gate)) begin
                    state_nxt = IDLE;
                    acc_nxt   = '0;
                end else begin
                    state_nxt = gate ? RUN : RELEASE;
                end
            end
            default: begin
                state_nxt = IDLE;
                acc_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            acc        <= '0;
            duty_q     <= '0;
            level_q    <= '0;
            vol_q      <= '0;
            vld_q      <= 1'b0;
            cycle_wrap <= 1'b0;
        end else begin
            vld_q      <= sample_tick;
            cycle_wrap <= sample_tick & wrap_nxt;
            if (sample_tick) begin
                state   <= state_nxt;
                acc     <= acc_nxt;
                duty_q  <= duty_nxt;
                level_q <= level_nxt;
                vol_q   <= volume;
            end
        end
    end

    // |level| * volume < 2^(DATA_W+VOL_W-1), so the product never overflows this width.
    assign level_ext = {{VOL_W{level_q[DATA_W-1]}}, level_q};
    assign vol_ext   = {{DATA_W{1'b0}}, vol_q};
    assign prod      = level_ext * vol_ext;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= vld_q;
            if (vld_q) begin
                data_out <= DATA_W'(prod >>> VOL_W);
            end
        end
    end

endmodule

// File: tb/tb_pulse_wave_gen.sv
// Bench for pulse_wave_gen: directed scenarios plus random stimulus against a per-tick reference model.
module tb_pulse_wave_gen;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 24;
    localparam int DUTY_W = 8;
    localparam int VOL_W  = 8;
    localparam int AMP    = 32767;
    localparam int POS    = 32639;
    localparam int NEG    = -32640;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     sample_tick;
    logic                     gate;
    logic [ACC_W-1:0]         phase_inc;
    logic [DUTY_W-1:0]        duty;
    logic [VOL_W-1:0]         volume;
    logic signed [DATA_W-1:0] data_out;
    logic                     data_valid;
    logic                     cycle_wrap;

    always #5 clk = ~clk;

    pulse_wave_gen #(.DATA_W(DATA_W), .ACC_W(ACC_W), .DUTY_W(DUTY_W), .VOL_W(VOL_W)) dut (
        .clk(clk), .reset(reset), .sample_tick(sample_tick), .gate(gate),
        .phase_inc(phase_inc), .duty(duty), .volume(volume),
        .data_out(data_out), .data_valid(data_valid), .cycle_wrap(cycle_wrap)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: note mode 0=off 1=held 2=released, phase as a plain integer.
    int     m_mode;
    longint m_phase;
    int     m_dq;
    bit     m_s1v;
    int     m_s1l, m_s1vol;
    bit     m_wrap, m_dv;
    int     m_dout;

    int obs [0:4095];
    int n_samp, n_wrap;

    function automatic int scale(input int lvl, input int vol);
        longint p;
        longint d;
        p = longint'(lvl) * vol;
        d = longint'(1) << VOL_W;
        if (p >= 0) return int'(p / d);
        return -int'((-p + d - 1) / d);
    endfunction

    task automatic model_edge();
        longint span, nxt;
        int     lvl;
        bit     w;
        span = longint'(1) << ACC_W;
        if (reset) begin
            m_mode = 0; m_phase = 0; m_dq = 0;
            m_s1v = 0; m_s1l = 0; m_s1vol = 0;
            m_wrap = 0; m_dv = 0; m_dout = 0;
        end else begin
            m_dv = m_s1v;
            if (m_s1v) m_dout = scale(m_s1l, m_s1vol);
            m_wrap = 0;
            m_s1v = sample_tick;
            if (sample_tick) begin
                lvl = 0;
                if (m_mode == 0) begin
                    if (gate) begin
                        m_mode  = 1;
                        m_dq    = int'(duty);
                        lvl     = (0 < m_dq) ? AMP : -AMP;
                        m_phase = longint'(phase_inc);
                    end
                end else begin
                    lvl = (m_phase / (longint'(1) << (ACC_W - DUTY_W)) < m_dq) ? AMP : -AMP;
                    nxt = m_phase + longint'(phase_inc);
                    w   = (nxt >= span);
                    if (w) begin
                        m_wrap = 1;
                        m_dq   = int'(duty);
                    end
                    if (w && (m_mode == 2 || !gate)) begin
                        m_mode  = 0;
                        m_phase = 0;
                    end else begin
                        m_mode  = gate ? 1 : 2;
                        m_phase = nxt % span;
                    end
                end
                m_s1l   = lvl;
                m_s1vol = int'(volume);
            end
        end
    endtask

    task automatic check(input string tag, input logic signed [31:0] o, input logic signed [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        model_edge();
        #1;
        check("data_valid", 32'(data_valid), 32'(m_dv));
        check("cycle_wrap", 32'(cycle_wrap), 32'(m_wrap));
        check("data_out", 32'(data_out), m_dout);
        if (data_valid === 1'b1 && n_samp < 4096) begin
            obs[n_samp] = 32'(data_out);
            n_samp++;
        end
        if (cycle_wrap === 1'b1) n_wrap++;
    endtask

    task automatic tick(input int gap);
        sample_tick = 1'b1;
        clk_step();
        sample_tick = 1'b0;
        repeat (gap - 1) clk_step();
    endtask

    task automatic start_scn();
        reset = 1'b1;
        sample_tick = 1'b0;
        gate = 1'b0;
        repeat (2) clk_step();
        reset = 1'b0;
        n_samp = 0;
        n_wrap = 0;
        clk_step();
    endtask

    function automatic int count_val(input int lo, input int hi, input int v);
        int n = 0;
        for (int i = lo; i <= hi; i++) if (obs[i] == v) n++;
        return n;
    endfunction

    initial begin
        reset = 1'b1; sample_tick = 1'b0; gate = 1'b0;
        phase_inc = 24'h010000; duty = 8'd128; volume = 8'd255;
        n_samp = 0; n_wrap = 0;

        // Reset state
        repeat (3) clk_step();
        check("rst_data_out", 32'(data_out), 0);
        check("rst_valid", 32'(data_valid), 0);
        check("rst_wrap", 32'(cycle_wrap), 0);

        // Default square wave, two full periods
        start_scn();
        gate = 1'b1;
        for (int i = 0; i < 512; i++) tick(4);
        repeat (3) clk_step();
        check("def_first", obs[0], POS);
        check("def_127", obs[127], POS);
        check("def_128", obs[128], NEG);
        check("def_high_p1", count_val(0, 255, POS), 128);
        check("def_high_p2", count_val(256, 511, POS), 128);
        check("def_wraps", n_wrap, 2);

        // Duty change mid-period only lands after the wrap
        start_scn();
        gate = 1'b1; duty = 8'd128;
        for (int i = 0; i < 512; i++) begin
            if (i == 40) duty = 8'd64;
            tick(4);
        end
        repeat (3) clk_step();
        check("duty_p1", count_val(0, 255, POS), 128);
        check("duty_p2", count_val(256, 511, POS), 64);
        check("duty_319", obs[319], POS);
        check("duty_320", obs[320], NEG);

        // Gate drop: release to end of period, then silence
        start_scn();
        duty = 8'd128;
        for (int i = 0; i < 300; i++) begin
            gate = (i < 100);
            tick(4);
        end
        repeat (3) clk_step();
        check("rel_nsamp", n_samp, 300);
        check("rel_255", obs[255], NEG);
        check("rel_256", obs[256], 0);
        check("rel_299", obs[299], 0);
        check("rel_wraps", n_wrap, 1);

        // Gate re-raised during release keeps the note
        start_scn();
        for (int i = 0; i < 300; i++) begin
            gate = (i < 100) || (i >= 200);
            tick(4);
        end
        repeat (3) clk_step();
        check("rer_200", obs[200], NEG);
        check("rer_256", obs[256], POS);
        check("rer_wraps", n_wrap, 1);

        // Volume 0
        start_scn();
        gate = 1'b1; volume = 8'd0;
        for (int i = 0; i < 20; i++) tick(2);
        repeat (3) clk_step();
        check("vol0_nsamp", n_samp, 20);
        check("vol0_zero", count_val(0, 19, 0), 20);

        // Duty 0
        start_scn();
        gate = 1'b1; volume = 8'd255; duty = 8'd0;
        for (int i = 0; i < 20; i++) tick(3);
        repeat (3) clk_step();
        check("duty0_low", count_val(0, 19, NEG), 20);

        // Latency and back-to-back ticks
        start_scn();
        gate = 1'b1; duty = 8'd128;
        sample_tick = 1'b1;
        clk_step();
        check("lat1_valid", 32'(data_valid), 0);
        sample_tick = 1'b0;
        clk_step();
        check("lat2_valid", 32'(data_valid), 1);
        check("lat2_data", 32'(data_out), POS);
        clk_step();
        check("lat3_valid", 32'(data_valid), 0);
        check("lat3_hold", 32'(data_out), POS);
        sample_tick = 1'b1;
        repeat (50) clk_step();
        sample_tick = 1'b0;
        repeat (3) clk_step();
        check("b2b_nsamp", n_samp, 51);

        // Reset mid-note with a coincident tick
        start_scn();
        gate = 1'b1; duty = 8'd40;
        sample_tick = 1'b1;
        repeat (50) clk_step();
        reset = 1'b1;
        clk_step();
        check("mrst_valid", 32'(data_valid), 0);
        check("mrst_data", 32'(data_out), 0);
        check("mrst_wrap", 32'(cycle_wrap), 0);
        reset = 1'b0; sample_tick = 1'b0;
        clk_step();
        check("mrst_post", 32'(data_out), 0);
        n_samp = 0;
        tick(4);
        repeat (2) clk_step();
        check("mrst_restart_n", n_samp, 1);
        check("mrst_restart", obs[0], POS);

        // Random stimulus against the model
        start_scn();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 149) == 0) begin
                case ($urandom_range(0, 3))
                    0: phase_inc = '0;
                    1: phase_inc = 24'($urandom_range(1, 32'h3FFFF));
                    2: phase_inc = 24'($urandom);
                    default: phase_inc = 24'h010000;
                endcase
                duty   = 8'($urandom);
                volume = 8'($urandom);
            end
            if ($urandom_range(0, 39) == 0) gate = ~gate;
            sample_tick = ($urandom_range(0, 2) == 0);
            reset = ($urandom_range(0, 599) == 0);
            clk_step();
        end
        reset = 1'b0; sample_tick = 1'b0;
        repeat (3) clk_step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
